// File: rtl/bitwise_alu_pkg.sv
// Shared op codes and the per-bit logic function for bitwise_alu_pipe.
// Optional accumulator build is selected with BITWISE_ALU_ACC_EN.
package bitwise_alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_ACC  = 3'b111;

  typedef enum logic [2:0] {
    ALU_AND  = OP_AND,
    ALU_OR   = OP_OR,
    ALU_XOR  = OP_XOR,
    ALU_XNOR = OP_XNOR,
    ALU_NAND = OP_NAND,
    ALU_NOR  = OP_NOR,
    ALU_NOTA = OP_NOTA,
    ALU_ACC  = OP_ACC
  } op_e;

  // Evaluated one bit at a time so a single function serves every WIDTH.
  // Op 111 falls through to a pass-through; the caller overrides it.
  function automatic logic bw_op(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_NOTA: r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_alu_core.sv
// Combinational result and flag generation for bitwise_alu_pipe.
// BITWISE_ALU_ACC_EN adds the accumulator operand used by op 111.
module bitwise_alu_core
  import bitwise_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BITWISE_ALU_ACC_EN
  input  logic [WIDTH-1:0] acc_base,
`endif
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             parity
);

  function automatic logic odd_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Result mux and flags derived from the pre-register result.
  always_comb begin
    res = {WIDTH{1'b0}};
    case (op_e'(op))
      ALU_ACC: begin
`ifdef BITWISE_ALU_ACC_EN
        res = acc_base ^ a;
`else
        res = a;
`endif
      end
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          res[i] = bw_op(op, a[i], b[i]);
        end
      end
    endcase
    zero   = (res == {WIDTH{1'b0}});
    parity = odd_parity(res);
  end

endmodule

// File: rtl/bitwise_alu_pipe.sv
// One-stage registered bitwise ALU with valid/ready handshakes and a consumed-result counter.
// Define BITWISE_ALU_ACC_EN to build the running XOR accumulator behind op 111.
module bitwise_alu_pipe
  import bitwise_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] txn_count
);

  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_parity;

  // Ready passes straight through from the consumer so a full stage still streams.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

`ifdef BITWISE_ALU_ACC_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_base;

  // A clear in the same cycle as an ACC op takes effect before the XOR.
  assign acc_base = acc_clr ? {WIDTH{1'b0}} : acc;

  // Accumulator update: an accepted ACC op stores the new sum, otherwise acc_clr zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= {WIDTH{1'b0}};
    end else if (accept && (op == OP_ACC)) begin
      acc <= res;
    end else if (acc_clr) begin
      acc <= {WIDTH{1'b0}};
    end else begin
      acc <= acc;
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
`endif

  bitwise_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op      (op),
    .a       (a),
    .b       (b),
`ifdef BITWISE_ALU_ACC_EN
    .acc_base(acc_base),
`endif
    .res     (res),
    .zero    (res_zero),
    .parity  (res_parity)
  );

  // Output stage: load on accept, drain on consume, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      parity    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      f         <= res;
      zero      <= res_zero;
      parity    <= res_parity;
    end else if (consume) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Consumed-result counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= {CNT_W{1'b0}};
    end else if (consume) begin
      txn_count <= txn_count + CNT_W'(1);
    end else begin
      txn_count <= txn_count;
    end
  end

endmodule

// File: tb/tb_bitwise_alu_pipe.sv
// Scoreboard bench for bitwise_alu_pipe: directed test-plan cases plus randomized traffic.
// Follows BITWISE_ALU_ACC_EN to pick the expected behaviour of op 111.
module tb_bitwise_alu_pipe;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          acc_clr = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = 3'b000;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  f;
  logic          zero;
  logic          parity;
  logic [CW-1:0] txn_count;

  bitwise_alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .zero(zero), .parity(parity), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] f;
    logic         zero;
    logic         parity;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] m_acc = '0;
  int unsigned m_cnt = 0;
  bit          run_mon = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: results straight from the operation table.
  task automatic model_accept(input logic [W-1:0] aa, input logic [W-1:0] bb,
                              input logic [2:0] oo, input logic clr);
    logic [W-1:0] r;
    exp_t e;
    case (oo)
      3'd0: r = aa & bb;
      3'd1: r = aa | bb;
      3'd2: r = aa ^ bb;
      3'd3: r = ~(aa ^ bb);
      3'd4: r = ~(aa & bb);
      3'd5: r = ~(aa | bb);
      3'd6: r = ~aa;
      default: begin
`ifdef BITWISE_ALU_ACC_EN
        r = (clr ? '0 : m_acc) ^ aa;
        m_acc = r;
`else
        r = aa;
`endif
      end
    endcase
    if (oo != 3'd7 && clr) m_acc = '0;
    e.f = r;
    e.zero = (r == '0);
    e.parity = ($countones(r) % 2) == 1;
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus and advance the model if the bench expects an accept.
  task automatic cyc(input logic iv, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input logic [2:0] oo, input logic clr, input logic ordy);
    logic exp_rdy;
    @(negedge clk);
    in_valid = iv; a = aa; b = bb; op = oo; acc_clr = clr; out_ready = ordy;
    #2;
    if (rst_n) begin
      exp_rdy = (sb.size() == 0) || ordy;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (iv && exp_rdy) model_accept(aa, bb, oo, clr);
      else if (clr) m_acc = '0;
    end
  endtask

  // Monitor: compares the presented result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && run_mon) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
        check("txn_count", {28'd0, txn_count}, {28'd0, m_cnt[CW-1:0]});
        if (out_valid && sb.size() != 0) begin
          check("f", {16'd0, f}, {16'd0, sb[0].f});
          check("zero", {31'd0, zero}, {31'd0, sb[0].zero});
          check("parity", {31'd0, parity}, {31'd0, sb[0].parity});
          if (out_ready) begin
            void'(sb.pop_front());
            m_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_f", {16'd0, f}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_parity", {31'd0, parity}, 32'd0);
    check("rst_txn_count", {28'd0, txn_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); #3 rst_n = 1'b1;
    run_mon = 1'b1;

    // XOR basic case and counter start
    cyc(1'b1, 16'h0f0f, 16'h3333, 3'b010, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    check("xor_f", {16'd0, f}, 32'h3c3c);
    check("xor_valid", {31'd0, out_valid}, 32'd1);
    check("xor_txn_before", {28'd0, txn_count}, 32'd0);
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    check("xor_txn_after", {28'd0, txn_count}, 32'd1);

    // Back-to-back ops on aaaa/00ff
    cyc(1'b1, 16'haaaa, 16'h00ff, 3'b000, 1'b0, 1'b1);
    cyc(1'b1, 16'haaaa, 16'h00ff, 3'b001, 1'b0, 1'b1);
    check("b2b_and", {16'd0, f}, 32'h00aa);
    cyc(1'b1, 16'haaaa, 16'h00ff, 3'b011, 1'b0, 1'b1);
    check("b2b_or", {16'd0, f}, 32'haaff);
    cyc(1'b1, 16'haaaa, 16'h00ff, 3'b110, 1'b0, 1'b1);
    check("b2b_xnor", {16'd0, f}, 32'h55aa);
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    check("b2b_nota", {16'd0, f}, 32'h5555);

    // Zero flag from AND
    cyc(1'b1, 16'h00ff, 16'hff00, 3'b000, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    check("and_zero", {31'd0, zero}, 32'd1);

    // Backpressure: three stalled cycles with fresh operands offered
    cyc(1'b1, 16'hffff, 16'h0001, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h1234, 16'h4321, 3'b001, 1'b0, 1'b0);
      check("stall_f", {16'd0, f}, 32'hfffe);
    end
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    check("release_valid", {31'd0, out_valid}, 32'd0);

`ifdef BITWISE_ALU_ACC_EN
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b1, 1'b1);
    cyc(1'b1, 16'h1234, 16'h0000, 3'b111, 1'b0, 1'b1);
    cyc(1'b1, 16'h1234, 16'h0000, 3'b111, 1'b0, 1'b1);
    check("acc_first", {16'd0, f}, 32'h1234);
    cyc(1'b1, 16'h00f0, 16'h0000, 3'b111, 1'b1, 1'b1);
    check("acc_cancel", {16'd0, f}, 32'h0000);
    check("acc_cancel_zero", {31'd0, zero}, 32'd1);
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    check("acc_clr_same", {16'd0, f}, 32'h00f0);
`else
    cyc(1'b1, 16'hbeef, 16'h0000, 3'b111, 1'b1, 1'b1);
    cyc(1'b1, 16'hbeef, 16'h1111, 3'b111, 1'b0, 1'b1);
    check("pass_first", {16'd0, f}, 32'hbeef);
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    check("pass_second", {16'd0, f}, 32'hbeef);
`endif

    // Randomized traffic with random backpressure and clears
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 3'($urandom),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
    end

    // Reset while stalled
    cyc(1'b1, 16'h5a5a, 16'h0f0f, 3'b010, 1'b0, 1'b0);
    cyc(1'b1, 16'h1111, 16'h2222, 3'b001, 1'b0, 1'b0);
    @(negedge clk); #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_f", {16'd0, f}, 32'd0);
    check("midrst_txn_count", {28'd0, txn_count}, 32'd0);
    sb.delete();
    m_acc = '0;
    m_cnt = 0;
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    @(negedge clk); #3 rst_n = 1'b1;

    // Counter wrap: 16 consumed results return txn_count to 0
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, W'($urandom), W'($urandom), 3'b010, 1'b0, 1'b1);
    end
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1);
    check("wrap_txn_count", {28'd0, txn_count}, 32'd0);
    check("drain_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitwise_alu_pipe.md
# bitwise_alu_pipe

- Parametrised, registered bitwise logic unit with valid/ready handshakes on input and output.
- Generalises the fixed 16-bit XOR to eight selectable bitwise operations plus an optional running XOR accumulator (checksum) mode.
- Produces zero and parity flags and counts completed transactions.
- Sits between a producer and a consumer stream as a one-stage pipeline element that honours backpressure.

## Interface
- `WIDTH`, 16: operand and result width in bits, ≥ 2.
- `CNT_W`, 16: width of the transaction counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands and op are valid.
- `in_ready` out 1: unit can accept this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `op` in 3: operation select.
- `acc_clr` in 1: clear accumulator; sampled every cycle, independent of `in_valid`.
- `out_valid` out 1: result holds valid data.
- `out_ready` in 1: consumer accepts result.
- `f` out WIDTH: result.
- `zero` out 1: `f == 0`.
- `parity` out 1: XOR-reduce of `f` (1 = odd number of ones).
- `txn_count` out CNT_W: number of results consumed.

## Operation
- Op codes:
  - 000 AND; 001 OR; 010 XOR; 011 XNOR.
  - 100 NAND; 101 NOR; 110 NOT a (`b` ignored).
  - 111 ACC: `acc_next = acc ^ a`, `f = acc_next`, `acc <= acc_next`.
- Accept: `in_valid && in_ready`.
  - `f`, `zero` and `parity` are registered together on accept.
  - `out_valid` is set on accept.
- `in_ready = !out_valid || out_ready`. This is a combinational pass-through of `out_ready`, so full throughput is one result per cycle.
- Output consumed: `out_valid && out_ready`.
  - `txn_count` increments and wraps from `2^CNT_W-1` to 0.
  - `out_valid` clears unless a new accept occurs in the same cycle, in which case it stays 1 with the new data.
- Stall: while `out_valid && !out_ready`, `f`, `zero` and `parity` hold stable and no accept occurs.
- `acc_clr` alone: `acc <= 0`.
- `acc_clr` together with an accepted ACC op: clear applies first, so `acc <= a` and `f = a`.
- `acc_clr` together with a non-ACC accept: `acc <= 0` and the op proceeds normally.
- Arithmetic: pure bitwise, no carries; all results are exactly WIDTH bits.
- Undefined op codes do not exist; all eight are decoded.

## Timing
- Reset values: `out_valid` 0, `f` 0, `zero` 0, `parity` 0, `txn_count` 0, internal `acc` 0.
- `in_ready` is 1 when `rst_n` is high and `out_valid` is 0.
- Latency: an operand accepted at edge N gives `f` valid after edge N, with `out_valid` = 1 in cycle N+1.
- Reset mid-operation: any pending result is dropped immediately (asynchronous) and the accumulator is cleared.
- Reset deassertion takes effect at the next rising edge.
- `zero` and `parity` are never combinational from `a`/`b`; they change only on accept.

## Configuration
- Macro `BITWISE_ALU_ACC_EN`.
- Defined: the accumulator register and ACC op 111 are implemented as above.
- Undefined:
  - No accumulator register is built.
  - Op 111 is pass-through (`f = a`).
  - `acc_clr` is ignored; the port remains present.

## Structure
- Shared package `bitwise_alu_pkg` holds:
  - the op code localparams `OP_AND` … `OP_ACC` and a typedef `op_e` (3-bit enum);
  - the function `bw_op(op, a, b)` returning the combinational result for ops 000–110.
- One sub-module, `bitwise_alu_core`: combinational, WIDTH-parametrised, produces the pre-register result and flags. The top holds the handshake, output register, accumulator and counter.

## Test plan
- Reset, then `in_valid=1`, `a=16'h0f0f`, `b=16'h3333`, `op=010`, `out_ready=1` → next cycle `f=16'h3c3c`, `zero=0`, `parity=0`, `out_valid=1`, and `txn_count` reaches 1 on the following edge.
- `a=16'haaaa`, `b=16'h00ff`, with ops 000, 001, 011 and 110 back-to-back → `f` = 16'h00aa, 16'haaff, 16'hAAAA^16'h00ff inverted = 16'h55aa, 16'h5555; one result per cycle, `in_ready` stays 1.
- Backpressure: `out_ready=0` for 3 cycles after accepting XOR of `16'hffff`/`16'h0001` → `f=16'hfffe` held, `in_ready=0`, new `a` ignored; raising `out_ready` releases exactly one transaction.
- ACC (macro defined): `acc_clr` pulse, then ACC with `a=16'h1234`, then ACC with `a=16'h1234` → `f=16'h1234` then `f=16'h0000` with `zero=1`. `acc_clr` plus ACC with `a=16'h00f0` → `f=16'h00f0`.
- ACC (macro undefined): op 111 with `a=16'hbeef` → `f=16'hbeef` regardless of history or `acc_clr`.
- Assert `rst_n=0` mid-stall → `out_valid`, `f` and `txn_count` go to 0 immediately. The counter wraps to 0 after `2^CNT_W` consumed results (run with `CNT_W=4`: 16 results → 0).
